// File: rtl/saradc_sar_pkg.sv
// Shared types and default sizing for the SAR ADC successive-approximation controller.
package saradc_sar_pkg;

    localparam int SAR_NBITS = 7;
    localparam int SAR_NSAMP = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_GAP    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_BRK    = 3'd4,
        ST_TRY    = 3'd5,
        ST_FIN    = 3'd6
    } sar_state_e;

    // Switch-register update requested on the edge entering the named phase.
    typedef enum logic [2:0] {
        SW_NONE  = 3'd0,
        SW_CLEAR = 3'd1,
        SW_HOLD  = 3'd2,
        SW_BRK   = 3'd3,
        SW_TRY   = 3'd4,
        SW_FIN   = 3'd5,
        SW_IDLE  = 3'd6
    } sw_op_e;

endpackage

// File: rtl/saradc_sar_switchreg.sv
// LSB CDAC switch registers (CRH/CRL) and the decision vector; every update
// opens one side of a bit before the opposite side is closed.
module saradc_sar_switchreg
    import saradc_sar_pkg::*;
#(
    parameter int NBITS = SAR_NBITS,
    parameter int BW    = (NBITS > 1) ? $clog2(NBITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  sw_op_e           op_i,
    input  logic [BW-1:0]    idx_i,
    input  logic             comp_i,
    output logic [NBITS-1:0] crh_o,
    output logic [NBITS-1:0] crl_o,
    output logic [NBITS-1:0] dec_o
);

    localparam logic [BW-1:0] IDX_TOP = BW'(NBITS - 1);
    localparam logic [BW-1:0] IDX_ONE = BW'(1);

    logic [NBITS-1:0] crh_q, crh_d;
    logic [NBITS-1:0] crl_q, crl_d;
    logic [NBITS-1:0] dec_q, dec_d;
    logic [BW-1:0]    prev_s;

    assign prev_s = idx_i + IDX_ONE;

    // Next switch state; comp_i is the decision of the TRY that ends on this edge.
    always_comb begin
        crh_d = crh_q;
        crl_d = crl_q;
        dec_d = dec_q;
        case (op_i)
            SW_NONE: begin
            end
            SW_CLEAR: begin
                crh_d = '0;
                crl_d = '0;
            end
            SW_HOLD: begin
                crl_d = '1;
            end
            SW_BRK: begin
                crl_d[idx_i] = 1'b0;
                if (idx_i != IDX_TOP) begin
                    dec_d[prev_s] = comp_i;
                    if (!comp_i) begin
                        crh_d[prev_s] = 1'b0;
                    end else begin
                        crh_d[prev_s] = crh_q[prev_s];
                    end
                end else begin
                    dec_d = dec_q;
                end
            end
            SW_TRY: begin
                crh_d[idx_i] = 1'b1;
                if ((idx_i != IDX_TOP) && !dec_q[prev_s]) begin
                    crl_d[prev_s] = 1'b1;
                end else begin
                    crl_d = crl_d;
                end
            end
            SW_FIN: begin
                dec_d[0] = comp_i;
                if (!comp_i) begin
                    crh_d[0] = 1'b0;
                end else begin
                    crh_d[0] = crh_q[0];
                end
            end
            SW_IDLE: begin
                if (!dec_q[0]) begin
                    crl_d[0] = 1'b1;
                end else begin
                    crl_d[0] = crl_q[0];
                end
            end
            default: begin
                crh_d = crh_q;
            end
        endcase
    end

    // Switch and decision state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crh_q <= '0;
            crl_q <= '0;
            dec_q <= '0;
        end else begin
            crh_q <= crh_d;
            crl_q <= crl_d;
            dec_q <= dec_d;
        end
    end

    assign crh_o = crh_q;
    assign crl_o = crl_q;
    assign dec_o = dec_q;

endmodule

// File: rtl/saradc_sar_logic.sv
// SAR conversion sequencer: sample/gap/hold phases, per-bit BRK/TRY trials,
// registered CPRE/CHOLD/strobes and combinational complement outputs.
module saradc_sar_logic
    import saradc_sar_pkg::*;
#(
    parameter int NBITS = SAR_NBITS,
    parameter int NSAMP = SAR_NSAMP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             comp_i,
    output logic             cpre_o,
    output logic             cpreb_o,
    output logic             chold_o,
    output logic             choldb_o,
    output logic [NBITS-1:0] crh_o,
    output logic [NBITS-1:0] crhb_o,
    output logic [NBITS-1:0] crl_o,
    output logic [NBITS-1:0] crlb_o,
    output logic             comp_en_o,
    output logic [NBITS-1:0] dout_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int SW = $clog2(NSAMP + 1);
    localparam logic [BW-1:0] BIT_TOP   = BW'(NBITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [SW-1:0] SAMP_ONE  = SW'(1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(NSAMP);

    sar_state_e       state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [SW-1:0]    samp_q, samp_d;
    logic             cpre_q, cpre_d;
    logic             chold_q, chold_d;
    logic             comp_en_q, comp_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NBITS-1:0] dout_q, dout_d;
    sw_op_e           sw_op_s;
    logic [NBITS-1:0] crh_s, crl_s, dec_s;

    // Next-state, counters and registered-output updates.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        samp_d  = samp_q;
        cpre_d  = cpre_q;
        chold_d = chold_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        sw_op_s = SW_NONE;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SAMPLE;
                    samp_d  = SAMP_ONE;
                    cpre_d  = 1'b1;
                    chold_d = 1'b0;
                    sw_op_s = SW_CLEAR;
                end else begin
                    cpre_d  = 1'b0;
                    chold_d = 1'b0;
                end
            end
            ST_SAMPLE: begin
                if (samp_q == SAMP_LAST) begin
                    state_d = ST_GAP;
                    cpre_d  = 1'b0;
                end else begin
                    samp_d = samp_q + SAMP_ONE;
                end
            end
            ST_GAP: begin
                state_d = ST_HOLD;
                chold_d = 1'b1;
                sw_op_s = SW_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_BRK;
                bit_d   = BIT_TOP;
                sw_op_s = SW_BRK;
            end
            ST_BRK: begin
                state_d = ST_TRY;
                sw_op_s = SW_TRY;
            end
            ST_TRY: begin
                if (bit_q == '0) begin
                    state_d   = ST_FIN;
                    sw_op_s   = SW_FIN;
                    done_d    = 1'b1;
                    dout_d    = dec_s;
                    dout_d[0] = comp_i;
                end else begin
                    state_d = ST_BRK;
                    bit_d   = bit_q - BIT_ONE;
                    sw_op_s = SW_BRK;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                chold_d = 1'b0;
                sw_op_s = SW_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cpre_d  = 1'b0;
                chold_d = 1'b0;
            end
        endcase
        comp_en_d = (state_d == ST_TRY);
        busy_d    = (state_d != ST_IDLE);
    end

    // Sequencer state and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_q     <= '0;
            samp_q    <= '0;
            cpre_q    <= 1'b0;
            chold_q   <= 1'b0;
            comp_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            cpre_q    <= cpre_d;
            chold_q   <= chold_d;
            comp_en_q <= comp_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dout_q    <= dout_d;
        end
    end

    saradc_sar_switchreg #(
        .NBITS (NBITS),
        .BW    (BW)
    ) u_switchreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .op_i   (sw_op_s),
        .idx_i  (bit_d),
        .comp_i (comp_i),
        .crh_o  (crh_s),
        .crl_o  (crl_s),
        .dec_o  (dec_s)
    );

    assign cpre_o    = cpre_q;
    assign cpreb_o   = ~cpre_q;
    assign chold_o   = chold_q;
    assign choldb_o  = ~chold_q;
    assign crh_o     = crh_s;
    assign crhb_o    = ~crh_s;
    assign crl_o     = crl_s;
    assign crlb_o    = ~crl_s;
    assign comp_en_o = comp_en_q;
    assign dout_o    = dout_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;

endmodule
